// File: rtl/lutram_arb_pkg.sv
// Shared types and helpers for the LUTRAM access arbiter: FSM encodings,
// round-robin grant selection and one-hot to index conversion.
`ifndef BYTE_LEN_IN_BITS
`define BYTE_LEN_IN_BITS 8
`endif

package lutram_arb_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  // Helpers operate on a fixed maximum width; callers zero-extend and slice.
  localparam int RR_MAX_REQ = 32;
  localparam int RR_IDX_W   = 5;

  // First asserted request at or after ptr, wrapping at num_req.
  function automatic logic [RR_MAX_REQ-1:0] rr_grant(input logic [RR_MAX_REQ-1:0] req,
                                                     input int num_req,
                                                     input int ptr);
    logic [RR_MAX_REQ-1:0] grant;
    logic found;
    int idx;
    grant = '0;
    found = 1'b0;
    for (int off = 0; off < RR_MAX_REQ; off++) begin
      idx = ptr + off;
      if (idx >= num_req) idx = idx - num_req;
      if ((off < num_req) && !found && req[idx[RR_IDX_W-1:0]]) begin
        grant[idx[RR_IDX_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return grant;
  endfunction

  function automatic int rr_index(input logic [RR_MAX_REQ-1:0] onehot);
    int idx;
    idx = 0;
    for (int i = 0; i < RR_MAX_REQ; i++) begin
      if (onehot[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer. The candidate is
// exposed so the parent can veto it through hold_in before it becomes a grant.
module rr_arbiter
  import lutram_arb_pkg::*;
#(
  parameter int NUM_REQUESTER = 4
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic [NUM_REQUESTER-1:0] req_in,
  input  logic                     hold_in,
  output logic [NUM_REQUESTER-1:0] cand_out,
  output logic [NUM_REQUESTER-1:0] grant_out
);

  localparam int PTR_W = (NUM_REQUESTER > 1) ? $clog2(NUM_REQUESTER) : 1;

  logic [PTR_W-1:0]      ptr_q;
  logic [PTR_W-1:0]      ptr_d;
  logic [RR_MAX_REQ-1:0] cand_full;
  logic                  unused_cand_hi;

  assign cand_full      = rr_grant(RR_MAX_REQ'(req_in), NUM_REQUESTER, int'(ptr_q));
  assign cand_out       = cand_full[NUM_REQUESTER-1:0];
  assign unused_cand_hi = ^cand_full;
  assign grant_out      = hold_in ? '0 : cand_out;

  // Pointer moves one past the winner; a withheld or empty cycle leaves it.
  always_comb begin
    int g;
    g     = rr_index(RR_MAX_REQ'(grant_out));
    ptr_d = ptr_q;
    if (|grant_out) begin
      ptr_d = (g == NUM_REQUESTER - 1) ? '0 : PTR_W'(g + 1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/lutram_access_arbiter.sv
// Shares one dual-port LUTRAM between NUM_REQUESTER requesters with separate
// write and read round-robin arbiters. LUTRAM_ARB_INIT_SWEEP_EN enables a
// power-up sweep that zeroes every set before requests are accepted.
`ifndef BYTE_LEN_IN_BITS
`define BYTE_LEN_IN_BITS 8
`endif

module lutram_access_arbiter
  import lutram_arb_pkg::*;
#(
  parameter int NUM_REQUESTER              = 4,
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int NUM_SET                    = 64,
  parameter int SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
  parameter int WRITE_MASK_LEN             = SINGLE_ENTRY_WIDTH_IN_BITS / `BYTE_LEN_IN_BITS
) (
  input  logic                                                clk_in,
  input  logic                                                reset_in,
  // A request transfers in a cycle where req_valid_in[i] & req_ready_out[i];
  // ready is combinational from valid and never asserts without it.
  input  logic [NUM_REQUESTER-1:0]                            req_valid_in,
  input  logic [NUM_REQUESTER-1:0]                            req_is_write_in,
  input  logic [NUM_REQUESTER*SET_PTR_WIDTH_IN_BITS-1:0]      req_addr_in,
  input  logic [NUM_REQUESTER*WRITE_MASK_LEN-1:0]             req_write_en_in,
  input  logic [NUM_REQUESTER*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] req_data_in,
  output logic [NUM_REQUESTER-1:0]                            req_ready_out,
  output logic [NUM_REQUESTER-1:0]                            resp_valid_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]               resp_data_out,
  output logic                                                resp_hit_out,
  output logic                                                write_port_access_en_out,
  output logic [WRITE_MASK_LEN-1:0]                           write_port_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]                    write_port_access_set_addr_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]               write_port_data_out,
  output logic                                                read_port_access_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]                    read_port_access_set_addr_out,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]               read_port_data_in,
  input  logic                                                read_port_valid_in,
  output logic                                                init_done_out,
  output logic                                                fsm_state_out
);

  localparam int SW = SET_PTR_WIDTH_IN_BITS;
  localparam int MW = WRITE_MASK_LEN;
  localparam int DW = SINGLE_ENTRY_WIDTH_IN_BITS;

`ifdef LUTRAM_ARB_INIT_SWEEP_EN
  localparam arb_state_e RESET_STATE = ST_INIT;
`else
  localparam arb_state_e RESET_STATE = ST_RUN;
`endif

  arb_state_e              state_q;
  arb_state_e              state_d;
  logic                    run_active;
  logic                    sweep_active;
  logic [NUM_REQUESTER-1:0] wr_req;
  logic [NUM_REQUESTER-1:0] rd_req;
  logic [NUM_REQUESTER-1:0] wr_grant;
  logic [NUM_REQUESTER-1:0] rd_grant;
  logic [NUM_REQUESTER-1:0] rd_cand;
  logic [NUM_REQUESTER-1:0] unused_wr_cand;
  logic [NUM_REQUESTER-1:0] resp_valid_q;
  logic [SW-1:0]           wr_addr;
  logic [SW-1:0]           rd_addr;
  logic [MW-1:0]           wr_mask;
  logic [DW-1:0]           wr_data;
  logic                    rd_hazard;

  // Reset gates everything combinationally so nothing leaks while it is held.
  assign run_active = (state_q == ST_RUN) && !reset_in;
  assign wr_req     = req_valid_in & req_is_write_in & {NUM_REQUESTER{run_active}};
  assign rd_req     = req_valid_in & ~req_is_write_in & {NUM_REQUESTER{run_active}};

  rr_arbiter #(.NUM_REQUESTER(NUM_REQUESTER)) u_wr_arb (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .req_in    (wr_req),
    .hold_in   (1'b0),
    .cand_out  (unused_wr_cand),
    .grant_out (wr_grant)
  );

  rr_arbiter #(.NUM_REQUESTER(NUM_REQUESTER)) u_rd_arb (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .req_in    (rd_req),
    .hold_in   (rd_hazard),
    .cand_out  (rd_cand),
    .grant_out (rd_grant)
  );

  always_comb begin
    wr_addr = '0;
    wr_mask = '0;
    wr_data = '0;
    rd_addr = '0;
    for (int i = 0; i < NUM_REQUESTER; i++) begin
      if (wr_grant[i]) begin
        wr_addr = req_addr_in[i*SW +: SW];
        wr_mask = req_write_en_in[i*MW +: MW];
        wr_data = req_data_in[i*DW +: DW];
      end
      if (rd_cand[i]) rd_addr = req_addr_in[i*SW +: SW];
    end
  end

  // The LUTRAM is read-first, so a same-set read would return stale data.
  assign rd_hazard = (|wr_mask) && (|rd_cand) && (wr_addr == rd_addr);

`ifdef LUTRAM_ARB_INIT_SWEEP_EN
  logic [SW-1:0] init_cnt_q;

  always_ff @(posedge clk_in) begin
    if (reset_in)                init_cnt_q <= '0;
    else if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + SW'(1);
  end

  assign sweep_active = (state_q == ST_INIT) && !reset_in;
`else
  assign sweep_active = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (reset_in) state_q <= RESET_STATE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef LUTRAM_ARB_INIT_SWEEP_EN
      ST_INIT: if (init_cnt_q == SW'(NUM_SET - 1)) state_d = ST_RUN;
`else
      ST_INIT: state_d = ST_RUN;
`endif
      ST_RUN:  state_d = ST_RUN;
      default: state_d = RESET_STATE;
    endcase
  end

  always_comb begin
    write_port_access_en_out       = 1'b0;
    write_port_write_en_out        = '0;
    write_port_access_set_addr_out = '0;
    write_port_data_out            = '0;
    if (sweep_active) begin
      write_port_access_en_out       = 1'b1;
      write_port_write_en_out        = '1;
`ifdef LUTRAM_ARB_INIT_SWEEP_EN
      write_port_access_set_addr_out = init_cnt_q;
`endif
    end else if (|wr_grant) begin
      write_port_access_en_out       = 1'b1;
      write_port_write_en_out        = wr_mask;
      write_port_access_set_addr_out = wr_addr;
      write_port_data_out            = wr_data;
    end
    read_port_access_en_out       = |rd_grant;
    read_port_access_set_addr_out = (|rd_grant) ? rd_addr : '0;
    req_ready_out                 = wr_grant | rd_grant;
    init_done_out                 = (state_q == ST_RUN) && !reset_in;
    fsm_state_out                 = state_q;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) resp_valid_q <= '0;
    else          resp_valid_q <= rd_grant;
  end

  assign resp_valid_out = resp_valid_q & ~{NUM_REQUESTER{reset_in}};
  assign resp_data_out  = read_port_data_in;
  assign resp_hit_out   = read_port_valid_in;

endmodule

// File: tb/tb_lutram_access_arbiter.sv
// Directed bench for lutram_access_arbiter with a behavioural read-first
// LUTRAM attached; covers LUTRAM_ARB_INIT_SWEEP_EN when that macro is set.
`timescale 1ns/1ps

module tb_lutram_access_arbiter;

`ifdef LUTRAM_ARB_INIT_SWEEP_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_in;
  logic [3:0]   req_valid;
  logic [3:0]   req_is_wr;
  logic [23:0]  req_addr;
  logic [31:0]  req_we;
  logic [255:0] req_data;
  logic [3:0]   ready;
  logic [3:0]   resp_valid;
  logic [63:0]  resp_data;
  logic         resp_hit;
  logic         wp_en;
  logic [7:0]   wp_we;
  logic [5:0]   wp_addr;
  logic [63:0]  wp_data;
  logic         rp_en;
  logic [5:0]   rp_addr;
  logic [63:0]  rp_data_q = '0;
  logic         rp_valid_q = 1'b0;
  logic         init_done;
  logic         fsm_state;

  logic [63:0]  mem [64] = '{default: '0};
  logic         vbit [64] = '{default: 1'b0};

  int tests = 0;
  int fails = 0;

  lutram_access_arbiter dut (
    .clk_in                         (clk),
    .reset_in                       (reset_in),
    .req_valid_in                   (req_valid),
    .req_is_write_in                (req_is_wr),
    .req_addr_in                    (req_addr),
    .req_write_en_in                (req_we),
    .req_data_in                    (req_data),
    .req_ready_out                  (ready),
    .resp_valid_out                 (resp_valid),
    .resp_data_out                  (resp_data),
    .resp_hit_out                   (resp_hit),
    .write_port_access_en_out       (wp_en),
    .write_port_write_en_out        (wp_we),
    .write_port_access_set_addr_out (wp_addr),
    .write_port_data_out            (wp_data),
    .read_port_access_en_out        (rp_en),
    .read_port_access_set_addr_out  (rp_addr),
    .read_port_data_in              (rp_data_q),
    .read_port_valid_in             (rp_valid_q),
    .init_done_out                  (init_done),
    .fsm_state_out                  (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Read-first LUTRAM: the read sees the contents from before this edge's write.
  always @(posedge clk) begin
    if (rp_en) begin
      rp_data_q  <= mem[rp_addr];
      rp_valid_q <= vbit[rp_addr];
    end
    if (wp_en) begin
      for (int b = 0; b < 8; b++) begin
        if (wp_we[b]) mem[wp_addr][b*8 +: 8] <= wp_data[b*8 +: 8];
      end
      if (|wp_we) vbit[wp_addr] <= 1'b1;
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_is_wr = '0;
    req_addr  = '0;
    req_we    = '0;
    req_data  = '0;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [5:0] addr,
                         input logic [7:0] mask, input logic [63:0] data);
    req_valid[i]          = 1'b1;
    req_is_wr[i]          = wr;
    req_addr[i*6 +: 6]    = addr;
    req_we[i*8 +: 8]      = mask;
    req_data[i*64 +: 64]  = data;
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic release_reset();
    reset_in = 1'b0;
`ifdef LUTRAM_ARB_INIT_SWEEP_EN
    for (int s = 0; s < 64; s++) begin
      settle();
      chk("sweep_wp_en", 64'(wp_en), 64'd1);
      chk("sweep_wp_addr", 64'(wp_addr), 64'(s));
      chk("sweep_wp_mask", 64'(wp_we), 64'hFF);
      chk("sweep_wp_data", wp_data, 64'd0);
      chk("sweep_ready", 64'(ready), 64'd0);
      chk("sweep_init_done", 64'(init_done), 64'd0);
      next_cycle();
    end
`endif
  endtask

  logic [3:0] rr_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    reset_in = 1'b1;
    clear_reqs();
    set_req(0, 1'b0, 6'd1, 8'h00, 64'd0);
    next_cycle();
    settle();
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_wp_en", 64'(wp_en), 64'd0);
    chk("rst_rp_en", 64'(rp_en), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
    next_cycle();
    clear_reqs();
    release_reset();
    settle();
    chk("init_done", 64'(init_done), 64'd1);

    // write then read of the same set
    next_cycle();
    set_req(0, 1'b1, 6'd5, 8'hFF, 64'hA5A5);
    settle();
    chk("a_ready", 64'(ready), 64'b0001);
    chk("a_wp_en", 64'(wp_en), 64'd1);
    chk("a_wp_addr", 64'(wp_addr), 64'd5);
    chk("a_wp_data", wp_data, 64'hA5A5);
    chk("a_wp_mask", 64'(wp_we), 64'hFF);
    chk("a_rp_en", 64'(rp_en), 64'd0);
    next_cycle();
    clear_reqs();
    set_req(1, 1'b0, 6'd5, 8'h00, 64'd0);
    settle();
    chk("b_ready", 64'(ready), 64'b0010);
    chk("b_rp_en", 64'(rp_en), 64'd1);
    chk("b_rp_addr", 64'(rp_addr), 64'd5);
    chk("b_wp_en", 64'(wp_en), 64'd0);
    chk("b_wp_mask", 64'(wp_we), 64'd0);
    next_cycle();
    clear_reqs();
    settle();
    chk("c_resp_valid", 64'(resp_valid), 64'b0010);
    chk("c_resp_data", resp_data, 64'hA5A5);
    chk("c_resp_hit", 64'(resp_hit), 64'd1);
    chk("c_ready", 64'(ready), 64'd0);

    // read grant, then reset the following cycle
    next_cycle();
    set_req(2, 1'b0, 6'd6, 8'h00, 64'd0);
    settle();
    chk("d_resp_idle", 64'(resp_valid), 64'd0);
    chk("d_ready", 64'(ready), 64'b0100);
    next_cycle();
    reset_in = 1'b1;
    settle();
    chk("e_resp_dropped", 64'(resp_valid), 64'd0);
    chk("e_ready", 64'(ready), 64'd0);
    chk("e_rp_en", 64'(rp_en), 64'd0);
    chk("e_init_done", 64'(init_done), 64'd0);

    // all four readers: rotation must restart at requester 0
    next_cycle();
    clear_reqs();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 6'(i), 8'h00, 64'd0);
    release_reset();
    settle();
    chk("rr_ready_0", 64'(ready), 64'(rr_seq[0]));
    for (int k = 1; k < 5; k++) begin
      next_cycle();
      settle();
      chk("rr_ready", 64'(ready), 64'(rr_seq[k]));
      chk("rr_resp_valid", 64'(resp_valid), 64'(rr_seq[k-1]));
      chk("rr_resp_hit", 64'(resp_hit), 64'(SWEEP));
      chk("rr_resp_data", resp_data, 64'd0);
    end

    // same-set write/read hazard
    next_cycle();
    clear_reqs();
    set_req(0, 1'b1, 6'd9, 8'hFF, 64'h1234_5678_9ABC_DEF0);
    set_req(2, 1'b0, 6'd9, 8'h00, 64'd0);
    settle();
    chk("h_resp_valid", 64'(resp_valid), 64'b0001);
    chk("h_ready", 64'(ready), 64'b0001);
    chk("h_rp_en", 64'(rp_en), 64'd0);
    next_cycle();
    clear_reqs();
    set_req(2, 1'b0, 6'd9, 8'h00, 64'd0);
    settle();
    chk("h2_ready", 64'(ready), 64'b0100);
    chk("h2_rp_en", 64'(rp_en), 64'd1);
    chk("h2_rp_addr", 64'(rp_addr), 64'd9);
    next_cycle();
    clear_reqs();
    settle();
    chk("h3_resp_valid", 64'(resp_valid), 64'b0100);
    chk("h3_resp_data", resp_data, 64'h1234_5678_9ABC_DEF0);
    chk("h3_resp_hit", 64'(resp_hit), 64'd1);

    // different sets: write and read granted together, partial mask
    next_cycle();
    set_req(0, 1'b1, 6'd3, 8'h0F, 64'hFFFF_FFFF_FFFF_FF77);
    set_req(1, 1'b0, 6'd4, 8'h00, 64'd0);
    settle();
    chk("o_ready", 64'(ready), 64'b0011);
    chk("o_wp_en", 64'(wp_en), 64'd1);
    chk("o_rp_en", 64'(rp_en), 64'd1);
    chk("o_wp_addr", 64'(wp_addr), 64'd3);
    chk("o_rp_addr", 64'(rp_addr), 64'd4);

    // zero-mask write to the read set is not a hazard
    next_cycle();
    clear_reqs();
    set_req(3, 1'b1, 6'd4, 8'h00, 64'hDEAD);
    set_req(0, 1'b0, 6'd4, 8'h00, 64'd0);
    settle();
    chk("p_ready", 64'(ready), 64'b1001);
    chk("p_wp_mask", 64'(wp_we), 64'd0);
    chk("p_resp_valid", 64'(resp_valid), 64'b0010);
    chk("p_resp_hit", 64'(resp_hit), 64'(SWEEP));
    chk("p_resp_data", resp_data, 64'd0);
    next_cycle();
    clear_reqs();
    set_req(1, 1'b0, 6'd3, 8'h00, 64'd0);
    settle();
    chk("q_ready", 64'(ready), 64'b0010);
    chk("q_resp_valid", 64'(resp_valid), 64'b0001);
    chk("q_resp_hit", 64'(resp_hit), 64'(SWEEP));
    chk("q_resp_data", resp_data, 64'd0);
    next_cycle();
    clear_reqs();
    settle();
    chk("r_resp_valid", 64'(resp_valid), 64'b0010);
    chk("r_resp_data", resp_data, 64'h0000_0000_FFFF_FF77);
    chk("r_resp_hit", 64'(resp_hit), 64'd1);
    next_cycle();
    settle();
    chk("s_resp_idle", 64'(resp_valid), 64'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
